// File: rtl/mem_io_pkg.sv
// Shared constants and types for the unified program/data memory with IO window.
package mem_io_pkg;

   typedef logic [1:0] io_off_t;

   localparam io_off_t IO_LED  = 2'd0;
   localparam io_off_t IO_SW   = 2'd1;
   localparam io_off_t IO_CYC  = 2'd2;
   localparam io_off_t IO_CTRL = 2'd3;

   localparam int IO_CTRL_LED_EN = 0;

   typedef enum logic {
      SCRUB,
      READY
   } scrub_state_e;

endpackage

// File: rtl/mem_io_if.sv
// Datapath-side bus of the memory: two read/write data ports and the fetch port.
interface mem_io_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 14
);
   logic [ADDR_WIDTH-1:0] addr1;
   logic [ADDR_WIDTH-1:0] addr2;
   logic [DATA_WIDTH-1:0] data_in1;
   logic [DATA_WIDTH-1:0] data_in2;
   logic                  we1;
   logic                  we2;
   logic [DATA_WIDTH-1:0] data_out1;
   logic [DATA_WIDTH-1:0] data_out2;
   logic [ADDR_WIDTH-1:0] pc;
   logic [DATA_WIDTH-1:0] instruction;

   modport master (
      output addr1, addr2, data_in1, data_in2, we1, we2, pc,
      input  data_out1, data_out2, instruction
   );

   modport slave (
      input  addr1, addr2, data_in1, data_in2, we1, we2, pc,
      output data_out1, data_out2, instruction
   );
endinterface

// File: rtl/mem_io_regs.sv
// IO window registers: LED, synchronised switches, free-running cycle counter, IO_CTRL.
module mem_io_regs
   import mem_io_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int SW_WIDTH   = 8,
   parameter int LED_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  hold_i,
   input  logic [SW_WIDTH-1:0]   switches_i,
   input  logic                  we1_i,
   input  io_off_t               off1_i,
   input  logic [LED_WIDTH-1:0]  led_wdata1_i,
   input  logic                  ctrl_wdata1_i,
   input  logic                  we2_i,
   input  io_off_t               off2_i,
   input  logic [LED_WIDTH-1:0]  led_wdata2_i,
   input  logic                  ctrl_wdata2_i,
   output logic [DATA_WIDTH-1:0] rdata1_o,
   output logic [DATA_WIDTH-1:0] rdata2_o,
   output logic [LED_WIDTH-1:0]  led_o
);

   logic [LED_WIDTH-1:0]  led_q, led_d;
   logic                  ctrl_q, ctrl_d;
   logic [SW_WIDTH-1:0]   sync1_q, sync2_q;
   logic [DATA_WIDTH-1:0] cyc_q;

   always_comb begin
      // NOTE: defaults first so every path assigns the next-state value and no latch is inferred.
      led_d  = led_q;
      ctrl_d = ctrl_q;
      // Port 2 is applied first so a write from port 1 to the same register overrides it.
      if (we2_i && off2_i == IO_LED)  led_d  = led_wdata2_i;
      if (we2_i && off2_i == IO_CTRL) ctrl_d = ctrl_wdata2_i;
      if (we1_i && off1_i == IO_LED)  led_d  = led_wdata1_i;
      if (we1_i && off1_i == IO_CTRL) ctrl_d = ctrl_wdata1_i;
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values; this is what makes IO reads read-first.
      if (!rst_n || hold_i) begin
         led_q  <= '0;
         ctrl_q <= 1'b1;
      end else begin
         led_q  <= led_d;
         ctrl_q <= ctrl_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         cyc_q   <= '0;
      end else begin
         sync1_q <= switches_i;
         sync2_q <= sync1_q;
         cyc_q   <= cyc_q + 1'b1;
      end
   end

   function automatic logic [DATA_WIDTH-1:0] io_read(input io_off_t off);
      case (off)
         IO_LED:  return DATA_WIDTH'(led_q);
         IO_SW:   return DATA_WIDTH'(sync2_q);
         IO_CYC:  return cyc_q;
         default: return DATA_WIDTH'(ctrl_q);
      endcase
   endfunction

   assign rdata1_o = io_read(off1_i);
   assign rdata2_o = io_read(off2_i);
   assign led_o    = ctrl_q ? led_q : '0;

endmodule

// File: rtl/mem_io_unit.sv
// Unified program/data RAM with two data ports, a fetch port and a 4-word IO window.
// Optional post-reset zero scrub is enabled by defining MEM_SCRUB_EN.
module mem_io_unit
   import mem_io_pkg::*;
#(
   parameter int    DATA_WIDTH = 16,
   parameter int    ADDR_WIDTH = 14,
   parameter int    IO_BASE    = 2**ADDR_WIDTH - 4,
   parameter int    SW_WIDTH   = 8,
   parameter int    LED_WIDTH  = 8,
   parameter string INIT_FILE  = ""
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mem_io_if.slave              bus,
   input  logic [SW_WIDTH-1:0]  switches,
   output logic [LED_WIDTH-1:0] led,
   output logic                 busy
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] IO_LO = ADDR_WIDTH'(IO_BASE);
   localparam logic [ADDR_WIDTH-1:0] IO_HI = ADDR_WIDTH'(IO_BASE + 3);

   function automatic logic in_io(input logic [ADDR_WIDTH-1:0] a);
      return (a >= IO_LO) && (a <= IO_HI);
   endfunction

   function automatic io_off_t io_off(input logic [ADDR_WIDTH-1:0] a);
      return io_off_t'(a - IO_LO);
   endfunction

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  io1, io2, io_pc;
   logic                  ram_we1, ram_we2, io_we1, io_we2;
   logic                  scrub_we;
   logic [ADDR_WIDTH-1:0] scrub_idx;
   logic [DATA_WIDTH-1:0] io_rdata1, io_rdata2;
   logic [DATA_WIDTH-1:0] dout1_q, dout2_q, instr_q;

   assign io1   = in_io(bus.addr1);
   assign io2   = in_io(bus.addr2);
   assign io_pc = in_io(bus.pc);

   // Port 1 wins a same-address RAM collision; IO collisions resolve inside mem_io_regs.
   assign ram_we1 = bus.we1 && !io1 && !busy;
   assign ram_we2 = bus.we2 && !io2 && !busy && !(ram_we1 && bus.addr1 == bus.addr2);
   assign io_we1  = bus.we1 && io1 && !busy;
   assign io_we2  = bus.we2 && io2 && !busy;

`ifdef MEM_SCRUB_EN
   scrub_state_e          state_q, state_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= SCRUB;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      if (state_q == SCRUB) begin
         idx_d = idx_q + 1'b1;
         if (idx_q == '1) state_d = READY;
      end
   end

   always_comb begin
      busy      = (state_q == SCRUB);
      scrub_we  = busy && rst_n;
      scrub_idx = idx_q;
   end
`else
   assign busy      = 1'b0;
   assign scrub_we  = 1'b0;
   assign scrub_idx = '0;
`endif

   always_ff @(posedge clk) begin
      // NOTE: the array has no reset; clearing it is the scrub FSM's job so it stays a plain RAM.
      if (scrub_we) begin
         mem[scrub_idx] <= '0;
      end else begin
         if (ram_we2) mem[bus.addr2] <= bus.data_in2;
         if (ram_we1) mem[bus.addr1] <= bus.data_in1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || busy) begin
         dout1_q <= '0;
         dout2_q <= '0;
         instr_q <= '0;
      end else begin
         dout1_q <= io1   ? io_rdata1 : mem[bus.addr1];
         dout2_q <= io2   ? io_rdata2 : mem[bus.addr2];
         instr_q <= io_pc ? '0        : mem[bus.pc];
      end
   end

   assign bus.data_out1   = dout1_q;
   assign bus.data_out2   = dout2_q;
   assign bus.instruction = instr_q;

   mem_io_regs #(
      .DATA_WIDTH (DATA_WIDTH),
      .SW_WIDTH   (SW_WIDTH),
      .LED_WIDTH  (LED_WIDTH)
   ) u_regs (
      .clk           (clk),
      .rst_n         (rst_n),
      .hold_i        (busy),
      .switches_i    (switches),
      .we1_i         (io_we1),
      .off1_i        (io_off(bus.addr1)),
      .led_wdata1_i  (bus.data_in1[LED_WIDTH-1:0]),
      .ctrl_wdata1_i (bus.data_in1[IO_CTRL_LED_EN]),
      .we2_i         (io_we2),
      .off2_i        (io_off(bus.addr2)),
      .led_wdata2_i  (bus.data_in2[LED_WIDTH-1:0]),
      .ctrl_wdata2_i (bus.data_in2[IO_CTRL_LED_EN]),
      .rdata1_o      (io_rdata1),
      .rdata2_o      (io_rdata2),
      .led_o         (led)
   );

endmodule
